imem_loader: RTL

- Write-side counterpart of the IMEM instruction-fetch read port: loads program words into instruction memory before the CPU runs.
- Accepts a byte stream (valid/ready), parses a 2-byte word-count header, assembles little-endian 32-bit instructions and issues one IMEM write per word at byte addresses BASE_ADDR, +4, +8, ...
- Holds the CPU (cpu_hold) while loading; sits between the host/UART byte source and the IMEM write port.

---
 rtl/imem_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader -- loads program words into instruction memory before the CPU runs.
//
// It takes a byte stream with valid/ready handshaking. The first two bytes are a
// little-endian word count. Each following group of four bytes is assembled
// little-endian into one 32-bit instruction. Each instruction is written to IMEM
// at byte addresses BASE_ADDR, +4, +8, ...
// The CPU is held in reset (cpu_hold) while a load is in progress, and stays held
// if the load fails.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   After the last word, one trailer byte is accepted. If it equals the XOR of all
//   data bytes in the session, the load ends in DONE; otherwise it ends in ERR.
//
// Parameters:
//   DEPTH      IMEM capacity in words; header counts above this are rejected
//   BASE_ADDR  byte address of the first word (4-aligned)
//
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   start               begin a session (honoured in IDLE/DONE/ERR only)
//   rx_data/valid/ready byte stream in
//   imem_we/addr/wdata  IMEM write port (one-cycle strobe per word)
//   cpu_hold, busy      CPU stall / session in progress
//   done, error         level status of the last session
//   words_written       words committed in the current/last session
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_HDR_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd7;
  // Every successful path goes through the trailer-byte check.
  localparam logic [2:0] S_FIN    = S_CHK;
`else
  localparam logic [2:0] S_FIN    = S_DONE;
`endif

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [15:0] r_count;
  logic [1:0]  r_bidx;
  logic [23:0] r_word;      // first three bytes of the word being assembled
  logic        r_rx_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_cpu_hold;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
  logic [15:0] r_words;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_xfer;
  logic        w_start;
  logic [15:0] w_hdr_count;
  logic        w_last;
  logic        w_busy_next;
  logic        w_ready_next;

  assign w_xfer      = rx_valid && r_rx_ready;
  assign w_start     = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_hdr_count = {rx_data, r_count[7:0]};
  assign w_last      = (r_words + 16'd1) == r_count;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_HDR_LO;
      S_HDR_LO: if (w_xfer) w_next = S_HDR_HI;
      S_HDR_HI: begin
        if (w_xfer) begin
          if (w_hdr_count == 16'd0)                 w_next = S_FIN;
          else if ({1'b0, w_hdr_count} > LP_DEPTH)  w_next = S_ERR;
          else                                      w_next = S_DATA;
        end
      end
      S_DATA:  if (w_xfer && r_bidx == 2'd3) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_FIN : S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:   if (w_xfer) w_next = (rx_data == r_csum) ? S_DONE : S_ERR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    w_busy_next  = (w_next == S_HDR_LO) || (w_next == S_HDR_HI) ||
                   (w_next == S_DATA)   || (w_next == S_WRITE);
    w_ready_next = (w_next == S_HDR_LO) || (w_next == S_HDR_HI) || (w_next == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (w_next == S_CHK) begin
      w_busy_next  = 1'b1;
      w_ready_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_bidx       <= '0;
      r_word       <= '0;
      r_rx_ready   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= BASE_ADDR;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_words      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_state    <= w_next;
      r_rx_ready <= w_ready_next;
      r_imem_we  <= (w_next == S_WRITE);
      r_busy     <= w_busy_next;
      r_cpu_hold <= w_busy_next || (w_next == S_ERR);
      r_done     <= (w_next == S_DONE);
      r_error    <= (w_next == S_ERR);

      if (w_start) begin
        r_words     <= '0;
        r_imem_addr <= BASE_ADDR;
        r_bidx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum      <= '0;
`endif
      end

      if (r_state == S_HDR_LO && w_xfer) r_count[7:0]  <= rx_data;
      if (r_state == S_HDR_HI && w_xfer) r_count[15:8] <= rx_data;

      if (r_state == S_DATA && w_xfer) begin
        r_bidx <= r_bidx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ rx_data;
`endif
        case (r_bidx)
          2'd0:    r_word[7:0]   <= rx_data;
          2'd1:    r_word[15:8]  <= rx_data;
          2'd2:    r_word[23:16] <= rx_data;
          default: r_imem_wdata  <= {rx_data, r_word};
        endcase
      end

      // The address and count advance after the strobe cycle, so the write itself
      // presents the current address.
      if (r_state == S_WRITE) begin
        r_imem_addr <= r_imem_addr + 32'd4;
        r_words     <= r_words + 16'd1;
      end
    end
  end

  assign rx_ready      = r_rx_ready;
  assign imem_we       = r_imem_we;
  assign imem_addr     = r_imem_addr;
  assign imem_wdata    = r_imem_wdata;
  assign cpu_hold      = r_cpu_hold;
  assign busy          = r_busy;
  assign done          = r_done;
  assign error         = r_error;
  assign words_written = r_words;

endmodule
